// File: rtl/inv_add_round_key_stage.sv
// inv_add_round_key_stage: registered AES AddRoundKey stage for the decryption datapath, with a 2-entry skid buffer.
// Optional feature macro: INV_ARK_PARITY_EN (per-byte even parity on stored round keys).
// Ports:
//   clk, rst                       clock, async active-high reset
//   key_we/key_addr/key_wdata      round-key store write port (indices 0..NR)
//   key_clear                      invalidate every stored key
//   in_valid/in_ready/in_data/in_round        upstream state handshake
//   out_valid/out_ready/out_data/out_round    downstream state handshake
//   out_skip_mix                   round tag is 0 or NR, so InvMixColumns is bypassed
//   err_no_key, err_parity         sticky error flags
module inv_add_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [RW-1:0] key_addr,
    input  logic [127:0]  key_wdata,
    input  logic          key_clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic [RW-1:0] in_round,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [RW-1:0] out_round,
    output logic          out_skip_mix,
    output logic          err_no_key,
    output logic          err_parity
);
    localparam int NK = NR + 1;
    localparam logic [RW-1:0] NRV = RW'(NR);
    logic [127:0] keys [0:NR];
    logic [NR:0] kvalid, kvalid_n;
    logic [127:0] s_data, rkey, xdata;
    logic [RW-1:0] s_round, ridx;
    logic s_valid, s_next, in_hit, kv, wr_ok, accept, drain;
    always_comb begin
        in_hit = in_round <= NRV;
        ridx = in_hit ? in_round : '0;
        kv = in_hit && kvalid[ridx];
        rkey = kv ? keys[ridx] : '0;
        xdata = in_data ^ rkey;
        wr_ok = key_we && (key_addr <= NRV);
        // clear is applied before the write so a simultaneous write survives
        kvalid_n = (key_clear ? '0 : kvalid) | (wr_ok ? (NK'(1) << key_addr) : '0);
        accept = in_valid && in_ready;
        drain = out_valid && out_ready;
        s_next = s_valid ? !drain : (accept && out_valid && !drain);
    end
    assign out_skip_mix = out_valid && (out_round == NRV || out_round == '0);
    always_ff @(posedge clk) begin
        if (wr_ok) keys[key_addr] <= key_wdata;
    end
`ifdef INV_ARK_PARITY_EN
    logic [15:0] kpar [0:NR];
    logic par_bad;
    function automatic logic [15:0] par16(input logic [127:0] d);
        for (int k = 0; k < 16; k++) par16[k] = ^d[8*k +: 8];
    endfunction
    always_ff @(posedge clk) begin
        if (wr_ok) kpar[key_addr] <= par16(key_wdata);
    end
    assign par_bad = accept && kv && (par16(keys[ridx]) != kpar[ridx]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_parity <= 1'b0;
        else if (par_bad) err_parity <= 1'b1;
    end
`else
    assign err_parity = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_round  <= '0;
            s_valid    <= 1'b0;
            s_data     <= '0;
            s_round    <= '0;
            in_ready   <= 1'b1;
            kvalid     <= '0;
            err_no_key <= 1'b0;
        end else begin
            kvalid     <= kvalid_n;
            err_no_key <= err_no_key | (accept && !kv);
            in_ready   <= !s_next;
            // in_ready is always !s_valid, so no accept can coincide with the S->M move
            if (drain && s_valid) begin
                out_data  <= s_data;
                out_round <= s_round;
                s_valid   <= 1'b0;
            end else if (accept && (!out_valid || drain)) begin
                out_valid <= 1'b1;
                out_data  <= xdata;
                out_round <= in_round;
            end else if (accept) begin
                s_valid <= 1'b1;
                s_data  <= xdata;
                s_round <= in_round;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
